spec_rename_table: RTL and testbench
====================================

// Module: spec_rename_table
// PURPOSE
// - Speculative RAT at the rename stage, 2-wide: maps lrs1/lrs2 to prs for instr0/instr1, returns old prd of lrd, installs new prd.
// - Read-side counterpart of archrenametable: on flush, rebuilt from the committed arch map over RESTORE_BEATS cycles.
// - Rename reads old_prd here; the freelist releases it at commit.
// PARAMETERS
// - NUM_LREG       32  logical regs; LREG_RANGE width = 5
// - RESTORE_BEATS  4   restore cycles; NUM_LREG/RESTORE_BEATS = 8 entries/beat
// PORTS
// - clock           in   1     clock, rising edge
// - reset_n         in   1     async, active-low reset
// - instr0_valid    in   1     instr0 rename request
// - instr0_need_to_wb in 1     instr0 writes lrd
// - instr0_lrs1/lrs2/lrd in 5  instr0 logical srcs/dest
// - instr0_prd      in   6     instr0 new preg from freelist
// - instr1_*        in   -     same set as instr0; instr1 is younger
// - instr0_prs1/prs2 out 6     instr0 mapped srcs
// - instr0_old_prd  out  6     instr0 lrd's mapping before this rename
// - instr1_prs1/prs2/old_prd out 6  instr1 results, bypassed from instr0
// - flush_valid     in   1     redirect; restore from arch map
// - arch_preg_flat  in   192   arch map; bits [6i+5:6i] = entry i
// - rename_ready    out  1     1 = table usable; 0 during restore
// BEHAVIOUR
// - Reset: entry i <= i; state IDLE; beat counter 0; rename_ready=1 right after reset.
// - Reads combinational from current table (0-cycle).
// - instr1 bypass: instr0 valid&need_to_wb and instr1_lrsX == instr0_lrd -> instr1_prsX = instr0_prd.
// - instr1_old_prd uses the same bypass on instr1_lrd.
// - Write en_k = instrk_valid & need_to_wb & rename_ready & ~flush_valid; entry lrd <= prd on next edge.
// - Both write same lrd: instr1_prd wins.
// - No x0 special case; decode clears need_to_wb for lrd==0.
// - FSM IDLE: flush_valid -> RESTORE, beat=0; that cycle's rename writes dropped.
// - FSM RESTORE: each cycle copy entries [8*beat .. 8*beat+7] from arch_preg_flat, beat++.
// - RESTORE exit: beat==RESTORE_BEATS-1 -> IDLE after copy; rename_ready high next cycle.
// - rename_ready=0 in RESTORE; reads return the partially restored table, upstream ignores them.
// - In RESTORE, instr writes are suppressed even when valid.
// - flush_valid in RESTORE restarts at beat 0, same cycle's copy discarded.
// - ROB drains older instrs before flush_valid; no commits during RESTORE, so arch_preg_flat is stable.
// - Restore latency: flush at cycle N -> rename_ready=1 at N+RESTORE_BEATS+1.
// - Beat counter: $clog2(RESTORE_BEATS) bits, no wrap beyond RESTORE_BEATS-1.
// - Async reset mid-RESTORE: immediate return to reset state (identity map, IDLE).
// STRUCTURE
// - defines.sv: LREG_RANGE, PREG_RANGE, NUM_LREG, RESTORE_BEATS defaults.
// - Package: typedef enum {SRAT_IDLE, SRAT_RESTORE} srat_state_t.
// - Sub-module spec_rat_restore_seq: FSM + beat counter.
// - spec_rat_restore_seq outputs busy, beat, per-entry restore_wren.
// - Top holds table array, write decode, bypass muxes.
// TESTING
// - Post-reset: instr0 lrs1=5, lrs2=31 -> prs1=5, prs2=31; rename_ready=1.
// - instr0 lrd=3 prd=40 wb=1; instr1 lrs1=3 lrd=3 prd=41 -> instr1_prs1=40, instr1_old_prd=40, instr0_old_prd=3.
// - Same case, next cycle: entry3 = 41.
// - Single write lrd=7 prd=50 then read lrs2=7 next cycle -> 50; need_to_wb=0 leaves entry unchanged.
// - Dirty entries 0..31 = 32+i; arch bus all 9; flush -> rename_ready low 4 cycles.
// - After that restore, rename_ready high, all entries 9; renames issued during restore cause no writes.
// - Flush again at beat 2 -> restart; rename_ready=1 exactly 5 cycles after 2nd flush, arch values present.
// - Assert reset_n low during beat 1 -> identity map, IDLE, rename_ready=1 once reset deasserts.

Source files
------------

// File: rtl/spec_rename_table_pkg.sv
// Shared sizes, index types and restore-sequencer state encoding for the
// speculative rename table.
package spec_rename_table_pkg;

    localparam int NUM_LREG         = 32;
    localparam int LREG_W           = 5;
    localparam int PREG_W           = 6;
    localparam int RESTORE_BEATS    = 4;
    localparam int ENTRIES_PER_BEAT = NUM_LREG / RESTORE_BEATS;
    localparam int BEAT_W           = $clog2(RESTORE_BEATS);

    typedef logic [LREG_W-1:0] lreg_t;
    typedef logic [PREG_W-1:0] preg_t;

    typedef enum logic {
        SRAT_IDLE,
        SRAT_RESTORE
    } srat_state_t;

endpackage

// File: rtl/spec_rat_restore_seq.sv
// Restore sequencer: walks the table in RESTORE_BEATS slices after a flush,
// producing per-entry copy enables; a flush while restoring restarts at beat 0.
module spec_rat_restore_seq
    import spec_rename_table_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush_valid,
    output logic                    busy,
    output logic [BEAT_W-1:0]       beat,
    output logic [NUM_LREG-1:0]     restore_wren,
    output srat_state_t             state
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RESTORE_BEATS - 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SRAT_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                SRAT_IDLE: begin
                    if (flush_valid) begin
                        state <= SRAT_RESTORE;
                        beat  <= '0;
                    end
                end
                SRAT_RESTORE: begin
                    if (flush_valid) begin
                        beat <= '0;
                    end else if (beat == LAST_BEAT) begin
                        state <= SRAT_IDLE;
                        beat  <= '0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                    state <= SRAT_IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    assign busy = (state == SRAT_RESTORE);

    // A flush landing mid-restore discards this beat's copy; the restart redoes it.
    always_comb begin
        restore_wren = '0;
        if (state == SRAT_RESTORE && !flush_valid) begin
            for (int b = 0; b < RESTORE_BEATS; b++) begin
                if (beat == BEAT_W'(b)) begin
                    restore_wren[b*ENTRIES_PER_BEAT +: ENTRIES_PER_BEAT] = '1;
                end
            end
        end
    end

endmodule

// File: rtl/spec_rename_table.sv
// Two-wide speculative rename table: combinational source/old-dest lookups with
// an instr0->instr1 bypass, and a staged rebuild from the arch map after a flush.
module spec_rename_table
    import spec_rename_table_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        instr0_valid,
    input  logic                        instr0_need_to_wb,
    input  logic [LREG_W-1:0]           instr0_lrs1,
    input  logic [LREG_W-1:0]           instr0_lrs2,
    input  logic [LREG_W-1:0]           instr0_lrd,
    input  logic [PREG_W-1:0]           instr0_prd,
    input  logic                        instr1_valid,
    input  logic                        instr1_need_to_wb,
    input  logic [LREG_W-1:0]           instr1_lrs1,
    input  logic [LREG_W-1:0]           instr1_lrs2,
    input  logic [LREG_W-1:0]           instr1_lrd,
    input  logic [PREG_W-1:0]           instr1_prd,
    output logic [PREG_W-1:0]           instr0_prs1,
    output logic [PREG_W-1:0]           instr0_prs2,
    output logic [PREG_W-1:0]           instr0_old_prd,
    output logic [PREG_W-1:0]           instr1_prs1,
    output logic [PREG_W-1:0]           instr1_prs2,
    output logic [PREG_W-1:0]           instr1_old_prd,
    input  logic                        flush_valid,
    input  logic [NUM_LREG*PREG_W-1:0]  arch_preg_flat,
    output logic                        rename_ready
);

    preg_t                  rat [NUM_LREG];
    logic                   busy;
    logic [BEAT_W-1:0]      beat;
    logic [NUM_LREG-1:0]    restore_wren;
    srat_state_t            seq_state;
    logic                   wen0;
    logic                   wen1;
    logic                   byp0;
    logic                   unused_dbg;

    spec_rat_restore_seq u_restore_seq (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush_valid  (flush_valid),
        .busy         (busy),
        .beat         (beat),
        .restore_wren (restore_wren),
        .state        (seq_state)
    );

    // Sequencer position stays observable at this level for checkers.
    assign unused_dbg   = ^{beat, seq_state};
    assign rename_ready = ~busy;

    assign wen0 = instr0_valid & instr0_need_to_wb & rename_ready & ~flush_valid;
    assign wen1 = instr1_valid & instr1_need_to_wb & rename_ready & ~flush_valid;

    // Restore copies and rename writes never overlap: writes need rename_ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LREG; i++) begin
                rat[i] <= preg_t'(i);
            end
        end else begin
            for (int i = 0; i < NUM_LREG; i++) begin
                if (restore_wren[i]) begin
                    rat[i] <= arch_preg_flat[i*PREG_W +: PREG_W];
                end else if (wen1 && instr1_lrd == LREG_W'(i)) begin
                    rat[i] <= instr1_prd;
                end else if (wen0 && instr0_lrd == LREG_W'(i)) begin
                    rat[i] <= instr0_prd;
                end
            end
        end
    end

    assign instr0_prs1    = rat[instr0_lrs1];
    assign instr0_prs2    = rat[instr0_lrs2];
    assign instr0_old_prd = rat[instr0_lrd];

    // instr1 is younger, so it must observe instr0's destination mapping.
    assign byp0 = instr0_valid & instr0_need_to_wb;

    assign instr1_prs1    = (byp0 && instr1_lrs1 == instr0_lrd) ? instr0_prd : rat[instr1_lrs1];
    assign instr1_prs2    = (byp0 && instr1_lrs2 == instr0_lrd) ? instr0_prd : rat[instr1_lrs2];
    assign instr1_old_prd = (byp0 && instr1_lrd  == instr0_lrd) ? instr0_prd : rat[instr1_lrd];

endmodule

// File: tb/tb_spec_rename_table.sv
// Directed and randomized bench for spec_rename_table against a behavioural
// map-plus-restore model.
module tb_spec_rename_table;

    logic         clock;
    logic         reset_n;
    logic         instr0_valid, instr0_need_to_wb;
    logic [4:0]   instr0_lrs1, instr0_lrs2, instr0_lrd;
    logic [5:0]   instr0_prd;
    logic         instr1_valid, instr1_need_to_wb;
    logic [4:0]   instr1_lrs1, instr1_lrs2, instr1_lrd;
    logic [5:0]   instr1_prd;
    logic [5:0]   instr0_prs1, instr0_prs2, instr0_old_prd;
    logic [5:0]   instr1_prs1, instr1_prs2, instr1_old_prd;
    logic         flush_valid;
    logic [191:0] arch_preg_flat;
    logic         rename_ready;

    int vectors;
    int miscompares;

    logic [5:0] map_m  [32];
    logic [5:0] arch_m [32];
    bit         m_ready;
    int         m_beat;

    spec_rename_table dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .instr0_valid      (instr0_valid),
        .instr0_need_to_wb (instr0_need_to_wb),
        .instr0_lrs1       (instr0_lrs1),
        .instr0_lrs2       (instr0_lrs2),
        .instr0_lrd        (instr0_lrd),
        .instr0_prd        (instr0_prd),
        .instr1_valid      (instr1_valid),
        .instr1_need_to_wb (instr1_need_to_wb),
        .instr1_lrs1       (instr1_lrs1),
        .instr1_lrs2       (instr1_lrs2),
        .instr1_lrd        (instr1_lrd),
        .instr1_prd        (instr1_prd),
        .instr0_prs1       (instr0_prs1),
        .instr0_prs2       (instr0_prs2),
        .instr0_old_prd    (instr0_old_prd),
        .instr1_prs1       (instr1_prs1),
        .instr1_prs2       (instr1_prs2),
        .instr1_old_prd    (instr1_old_prd),
        .flush_valid       (flush_valid),
        .arch_preg_flat    (arch_preg_flat),
        .rename_ready      (rename_ready)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) map_m[i] = 6'(i);
        m_ready = 1'b1;
        m_beat  = 0;
    endtask

    task automatic drive_arch();
        for (int i = 0; i < 32; i++) arch_preg_flat[i*6 +: 6] = arch_m[i];
    endtask

    task automatic clear_inputs();
        instr0_valid = 0; instr0_need_to_wb = 0; instr0_lrs1 = 0; instr0_lrs2 = 0;
        instr0_lrd = 0; instr0_prd = 0;
        instr1_valid = 0; instr1_need_to_wb = 0; instr1_lrs1 = 0; instr1_lrs2 = 0;
        instr1_lrd = 0; instr1_prd = 0;
        flush_valid = 0;
    endtask

    task automatic randomize_renames();
        instr0_valid = 1'($urandom_range(0, 1)); instr0_need_to_wb = 1'($urandom_range(0, 1));
        instr0_lrs1 = 5'($urandom); instr0_lrs2 = 5'($urandom);
        instr0_lrd = 5'($urandom); instr0_prd = 6'($urandom);
        instr1_valid = 1'($urandom_range(0, 1)); instr1_need_to_wb = 1'($urandom_range(0, 1));
        instr1_lrs1 = 5'($urandom); instr1_lrs2 = 5'($urandom);
        instr1_lrd = 5'($urandom); instr1_prd = 6'($urandom);
        // Bias toward collisions with instr0's destination.
        if ($urandom_range(0, 2) == 0) instr1_lrs1 = instr0_lrd;
        if ($urandom_range(0, 3) == 0) instr1_lrd  = instr0_lrd;
    endtask

    // Scoreboard: compare every output with the model, then advance the model at the edge.
    task automatic cycle();
        logic       b0;
        logic [5:0] e1s1, e1s2, e1od;
        #1;
        b0   = instr0_valid && instr0_need_to_wb;
        e1s1 = (b0 && instr1_lrs1 == instr0_lrd) ? instr0_prd : map_m[instr1_lrs1];
        e1s2 = (b0 && instr1_lrs2 == instr0_lrd) ? instr0_prd : map_m[instr1_lrs2];
        e1od = (b0 && instr1_lrd  == instr0_lrd) ? instr0_prd : map_m[instr1_lrd];
        chk("rename_ready",   32'(rename_ready),   32'(m_ready));
        chk("instr0_prs1",    32'(instr0_prs1),    32'(map_m[instr0_lrs1]));
        chk("instr0_prs2",    32'(instr0_prs2),    32'(map_m[instr0_lrs2]));
        chk("instr0_old_prd", 32'(instr0_old_prd), 32'(map_m[instr0_lrd]));
        chk("instr1_prs1",    32'(instr1_prs1),    32'(e1s1));
        chk("instr1_prs2",    32'(instr1_prs2),    32'(e1s2));
        chk("instr1_old_prd", 32'(instr1_old_prd), 32'(e1od));
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else if (m_ready) begin
            if (flush_valid) begin
                m_ready = 1'b0;
                m_beat  = 0;
            end else begin
                if (instr0_valid && instr0_need_to_wb) map_m[instr0_lrd] = instr0_prd;
                if (instr1_valid && instr1_need_to_wb) map_m[instr1_lrd] = instr1_prd;
            end
        end else if (flush_valid) begin
            m_beat = 0;
        end else begin
            for (int k = 0; k < 8; k++) map_m[m_beat*8 + k] = arch_m[m_beat*8 + k];
            m_beat++;
            if (m_beat == 4) begin
                m_ready = 1'b1;
                m_beat  = 0;
            end
        end
        @(negedge clock);
    endtask

    task automatic count_restore(input string tag, input bit renames);
        int n;
        n = 0;
        while (!rename_ready && n < 20) begin
            if (renames) begin
                randomize_renames();
                instr0_valid = 1; instr0_need_to_wb = 1;
            end
            cycle();
            n++;
        end
        chk(tag, 32'(n), 32'd4);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_inputs();
        for (int i = 0; i < 32; i++) arch_m[i] = 6'(i);
        drive_arch();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Post-reset identity reads
        instr0_lrs1 = 5; instr0_lrs2 = 31;
        #1;
        chk("reset_prs1",  32'(instr0_prs1), 32'd5);
        chk("reset_prs2",  32'(instr0_prs2), 32'd31);
        chk("reset_ready", 32'(rename_ready), 32'd1);
        cycle();

        // Same-lrd pair: bypass into instr1, instr1 wins the write
        instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrd = 3; instr0_prd = 40;
        instr1_valid = 1; instr1_need_to_wb = 1; instr1_lrs1 = 3; instr1_lrd = 3; instr1_prd = 41;
        #1;
        chk("byp_prs1",       32'(instr1_prs1),    32'd40);
        chk("byp_old_prd",    32'(instr1_old_prd), 32'd40);
        chk("i0_old_prd",     32'(instr0_old_prd), 32'd3);
        cycle();
        clear_inputs();
        instr0_lrs1 = 3;
        #1;
        chk("entry3_after_pair", 32'(instr0_prs1), 32'd41);
        cycle();

        // Single write then read; need_to_wb=0 leaves the entry alone
        instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrd = 7; instr0_prd = 50;
        cycle();
        instr0_valid = 1; instr0_need_to_wb = 0; instr0_lrd = 7; instr0_prd = 12; instr0_lrs2 = 7;
        #1;
        chk("entry7_written", 32'(instr0_prs2), 32'd50);
        cycle();
        clear_inputs();
        instr0_lrs2 = 7;
        #1;
        chk("entry7_no_wb", 32'(instr0_prs2), 32'd50);
        cycle();

        // Dirty every entry, then restore from an all-9 arch map
        for (int k = 0; k < 16; k++) begin
            instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrd = 5'(2*k);   instr0_prd = 6'(32 + 2*k);
            instr1_valid = 1; instr1_need_to_wb = 1; instr1_lrd = 5'(2*k+1); instr1_prd = 6'(33 + 2*k);
            cycle();
        end
        clear_inputs();
        for (int i = 0; i < 32; i++) arch_m[i] = 6'd9;
        drive_arch();
        flush_valid = 1; instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrd = 4; instr0_prd = 1;
        cycle();
        clear_inputs();
        count_restore("restore_len", 1'b1);
        clear_inputs();
        for (int k = 0; k < 16; k++) begin
            instr0_lrs1 = 5'(2*k); instr0_lrs2 = 5'(2*k+1);
            #1;
            chk("restored_a", 32'(instr0_prs1), 32'd9);
            chk("restored_b", 32'(instr0_prs2), 32'd9);
            cycle();
        end

        // Flush again at beat 2 restarts the walk
        for (int i = 0; i < 32; i++) arch_m[i] = 6'($urandom);
        drive_arch();
        flush_valid = 1;
        cycle();
        flush_valid = 0;
        cycle();
        cycle();
        flush_valid = 1;
        cycle();
        flush_valid = 0;
        count_restore("restart_len", 1'b0);
        for (int k = 0; k < 16; k++) begin
            instr0_lrs1 = 5'(2*k); instr0_lrs2 = 5'(2*k+1);
            cycle();
        end

        // Async reset during beat 1
        for (int i = 0; i < 32; i++) arch_m[i] = 6'(63 - i);
        drive_arch();
        flush_valid = 1;
        cycle();
        flush_valid = 0;
        cycle();
        reset_n = 1'b0;
        model_reset();
        instr0_lrs1 = 2;
        #1;
        chk("reset_mid_ready", 32'(rename_ready), 32'd1);
        chk("reset_mid_ident", 32'(instr0_prs1),  32'd2);
        cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            instr0_lrs1 = 5'(2*k); instr0_lrs2 = 5'(2*k+1);
            cycle();
        end

        // Randomized traffic with occasional flushes
        for (int n = 0; n < 600; n++) begin
            randomize_renames();
            flush_valid = ($urandom_range(0, 15) == 0);
            if (m_ready && !flush_valid && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 32; i++) arch_m[i] = 6'($urandom);
                drive_arch();
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
